// File: rtl/nios_sys_lcd_strobe_pio.sv
// Avalon-MM character-LCD port that wraps every DATA write in a timed E strobe.
// Optional done/irq support is enabled by defining LCD_STROBE_IRQ_EN.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | no transfer, busy low, next DATA write accepted
// SETUP   | data/RS valid, E low, waiting SETUP_CYC cycles
// PULSE   | E high for PULSE_CYC cycles
// HOLD    | E low, data/RS held for HOLD_CYC cycles
module nios_sys_lcd_strobe_pio #(
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 12,
    parameter int HOLD_CYC  = 2,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic              lcd_rs,
    output logic              lcd_e,
`ifdef LCD_STROBE_IRQ_EN
    output logic              irq,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_SETUP = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] C_PULSE = CNT_W'((PULSE_CYC > 0) ? PULSE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] C_HOLD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [DATA_W-1:0]  r_data;
    logic               r_lcd_rs;
    logic               r_rs_next;
    logic               r_lcd_e;
    logic               r_busy;
    logic               r_overrun;

    logic               w_wr;
    logic               w_wr_data;
    logic               w_wr_ctrl;
    logic               w_wr_stat;
    logic               w_accept;
    logic               w_unused;

    assign w_wr      = chipselect & ~write_n;
    assign w_wr_data = w_wr && (address == 2'd0);
    assign w_wr_ctrl = w_wr && (address == 2'd1);
    assign w_wr_stat = w_wr && (address == 2'd2);
    assign w_accept  = w_wr_data && (r_state == ST_IDLE);
    assign w_unused  = &{1'b0, writedata};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_data) begin
                    if (SETUP_CYC > 0) begin
                        w_state_nxt = ST_SETUP;
                        w_cnt_nxt   = C_SETUP;
                    end else begin
                        w_state_nxt = ST_PULSE;
                        w_cnt_nxt   = C_PULSE;
                    end
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_nxt   = C_PULSE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_PULSE: begin
                if (r_cnt == '0) begin
                    if (HOLD_CYC > 0) begin
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = C_HOLD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // lcd_e and busy are registered from the next state so they line up with the phase
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_data    <= '0;
            r_lcd_rs  <= 1'b0;
            r_rs_next <= 1'b0;
            r_lcd_e   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lcd_e <= (w_state_nxt == ST_PULSE);
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (w_accept) begin
                r_data   <= writedata[DATA_W-1:0];
                r_lcd_rs <= r_rs_next;
            end
            if (w_wr_ctrl)
                r_rs_next <= writedata[0];
            if (w_wr_data && (r_state != ST_IDLE))
                r_overrun <= 1'b1;
            else if (w_wr_stat && writedata[1])
                r_overrun <= 1'b0;
        end
    end

`ifdef LCD_STROBE_IRQ_EN
    logic r_irq_en;
    logic r_done;
    logic r_irq;
    logic w_done_set;

    assign w_done_set = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl)
                r_irq_en <= writedata[1];
            if (w_done_set)
                r_done <= 1'b1;
            else if (w_wr_stat && writedata[2])
                r_done <= 1'b0;
            r_irq <= r_done & r_irq_en;
        end
    end

    assign irq = r_irq;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata = 32'(r_data);
`ifdef LCD_STROBE_IRQ_EN
            2'd1: readdata = {30'd0, r_irq_en, r_rs_next};
            2'd2: readdata = {29'd0, r_done, r_overrun, r_busy};
`else
            2'd1: readdata = {31'd0, r_rs_next};
            2'd2: readdata = {30'd0, r_overrun, r_busy};
`endif
            default: readdata = '0;
        endcase
    end

    assign out_port = r_data;
    assign lcd_rs   = r_lcd_rs;
    assign lcd_e    = r_lcd_e;
    assign busy     = r_busy;

endmodule

// File: tb/tb_nios_sys_lcd_strobe_pio.sv
// Self-checking bench for nios_sys_lcd_strobe_pio: register table, directed strobe
// sequences, a zero-setup/hold instance and randomized traffic against a timing model.
module tb_nios_sys_lcd_strobe_pio;

    localparam int S   = 2;
    localparam int P   = 12;
    localparam int H   = 2;
    localparam int TOT = S + P + H;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        lcd_rs, lcd_e, busy;

    logic [1:0]  address_z;
    logic        chipselect_z;
    logic        write_n_z;
    logic [31:0] writedata_z;
    logic [31:0] readdata_z;
    logic [7:0]  out_port_z;
    logic        lcd_rs_z, lcd_e_z, busy_z;
`ifdef LCD_STROBE_IRQ_EN
    logic        irq, irq_z;
    localparam logic [31:0] RD_MASK = 32'h3;
`else
    localparam logic [31:0] RD_MASK = 32'hFFFF_FFFF;
`endif

    always #5 clk = ~clk;

    nios_sys_lcd_strobe_pio u_dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .lcd_rs(lcd_rs), .lcd_e(lcd_e),
`ifdef LCD_STROBE_IRQ_EN
        .irq(irq),
`endif
        .busy(busy)
    );

    nios_sys_lcd_strobe_pio #(.SETUP_CYC(0), .PULSE_CYC(1), .HOLD_CYC(0)) u_dut_z (
        .clk(clk), .reset(reset), .address(address_z), .chipselect(chipselect_z),
        .write_n(write_n_z), .writedata(writedata_z), .readdata(readdata_z),
        .out_port(out_port_z), .lcd_rs(lcd_rs_z), .lcd_e(lcd_e_z),
`ifdef LCD_STROBE_IRQ_EN
        .irq(irq_z),
`endif
        .busy(busy_z)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a transfer accepted in cycle t owns cycles t+1..t+TOT,
    // with E high in cycles t+S+1..t+S+P.
    int          m_cyc   = 0;
    int          m_start = -1000;
    logic [7:0]  m_data  = '0;
    logic        m_rs    = 1'b0;
    logic        m_rs_next = 1'b0;
    logic        m_ovr   = 1'b0;
    logic [31:0] rd_pre;

    function automatic logic m_busy(input int k);
        return (k >= m_start + 1) && (k <= m_start + TOT);
    endfunction

    function automatic logic m_e(input int k);
        return (k >= m_start + S + 1) && (k <= m_start + S + P);
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {24'd0, m_data};
            2'd1:    return {31'd0, m_rs_next};
            2'd2:    return {30'd0, m_ovr, m_busy(m_cyc)};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, m_cyc);
    endtask

    task automatic step(input logic rst, input logic cs, input logic wn,
                        input logic [1:0] a, input logic [31:0] wd);
        int old;
        @(negedge clk);
        reset = rst; chipselect = cs; write_n = wn; address = a; writedata = wd;
        #1;
        rd_pre = readdata;
        if (!rst) begin
            if (a == 2'd1 || a == 2'd2) chk("readdata", readdata & RD_MASK, m_read(a));
            else                         chk("readdata", readdata, m_read(a));
        end
        @(posedge clk);
        old = m_cyc;
        if (rst) begin
            m_start = -1000; m_data = '0; m_rs = 1'b0; m_rs_next = 1'b0; m_ovr = 1'b0;
        end else if (cs && !wn) begin
            case (a)
                2'd0: if (m_busy(old)) m_ovr = 1'b1;
                      else begin m_start = old; m_data = wd[7:0]; m_rs = m_rs_next; end
                2'd1: m_rs_next = wd[0];
                2'd2: if (wd[1]) m_ovr = 1'b0;
                default: ;
            endcase
        end
        m_cyc++;
        #1;
        chk("out_port", 32'(out_port), 32'(m_data));
        chk("lcd_rs",   32'(lcd_rs),   32'(m_rs));
        chk("lcd_e",    32'(lcd_e),    32'(m_e(m_cyc)));
        chk("busy",     32'(busy),     32'(m_busy(m_cyc)));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b1, 2'd0, 32'd0);
    endtask

    typedef struct {
        logic        cs;
        logic        wn;
        logic [1:0]  a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt[12];

    initial begin
        int e_first, e_cnt, b_cnt, guard;
        vt[0]  = '{1'b1, 1'b1, 2'd0, 32'h0,          32'h0};
        vt[1]  = '{1'b1, 1'b1, 2'd1, 32'h0,          32'h0};
        vt[2]  = '{1'b1, 1'b1, 2'd2, 32'h0,          32'h0};
        vt[3]  = '{1'b1, 1'b1, 2'd3, 32'h0,          32'h0};
        vt[4]  = '{1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF,  32'h0};
        vt[5]  = '{1'b1, 1'b1, 2'd3, 32'h0,          32'h0};
        vt[6]  = '{1'b1, 1'b0, 2'd1, 32'h1,          32'h0};
        vt[7]  = '{1'b1, 1'b1, 2'd1, 32'h0,          32'h1};
        vt[8]  = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFE,  32'h1};
        vt[9]  = '{1'b1, 1'b1, 2'd1, 32'h0,          32'h0};
        vt[10] = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF,  32'h0};
        vt[11] = '{1'b1, 1'b1, 2'd2, 32'h0,          32'h0};

        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'd0;
        chipselect_z = 1'b0; write_n_z = 1'b1; address_z = 2'd0; writedata_z = 32'd0;
        step(1'b1, 1'b0, 1'b1, 2'd0, 32'd0);
        step(1'b1, 1'b0, 1'b1, 2'd0, 32'd0);
        idle();

        // zero setup/hold instance: one-cycle strobe and busy
        @(negedge clk);
        chipselect_z = 1'b1; write_n_z = 1'b0; address_z = 2'd0; writedata_z = 32'hFF;
        @(posedge clk); #1;
        chk("z_lcd_e_on",  32'(lcd_e_z), 32'd1);
        chk("z_busy_on",   32'(busy_z),  32'd1);
        chk("z_out_ff",    32'(out_port_z), 32'hFF);
        @(negedge clk);
        chipselect_z = 1'b0; write_n_z = 1'b1;
        @(posedge clk); #1;
        chk("z_lcd_e_off", 32'(lcd_e_z), 32'd0);
        chk("z_busy_off",  32'(busy_z),  32'd0);
        @(negedge clk);
        chipselect_z = 1'b1; write_n_z = 1'b0; address_z = 2'd0; writedata_z = 32'h55;
        @(posedge clk); #1;
        chk("z_second_e",   32'(lcd_e_z), 32'd1);
        chk("z_second_out", 32'(out_port_z), 32'h55);
        @(negedge clk);
        write_n_z = 1'b1; address_z = 2'd2;
        #1 chk("z_status_busy", readdata_z & RD_MASK, 32'h1);
        @(posedge clk);
        @(negedge clk); #1;
        chk("z_status_idle", readdata_z & RD_MASK, 32'h0);
        chipselect_z = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step(1'b0, vt[i].cs, vt[i].wn, vt[i].a, vt[i].wd);
            chk($sformatf("table[%0d]", i), rd_pre & RD_MASK, vt[i].exp_rd);
        end

        // basic strobe: RS=1, DATA=0x41
        step(1'b0, 1'b1, 1'b0, 2'd1, 32'h1);
        step(1'b0, 1'b1, 1'b0, 2'd0, 32'h41);
        chk("basic_out", 32'(out_port), 32'h41);
        chk("basic_rs",  32'(lcd_rs), 32'd1);
        e_first = -1; e_cnt = 0; b_cnt = 0;
        for (int off = 1; off <= 22; off++) begin
            if (off > 1) idle();
            if (lcd_e) begin e_cnt++; if (e_first < 0) e_first = off; end
            if (busy) b_cnt++;
        end
        chk("basic_e_first", 32'(e_first), 32'd3);
        chk("basic_e_len",   32'(e_cnt),   32'd12);
        chk("basic_busy_len",32'(b_cnt),   32'd16);
        step(1'b0, 1'b1, 1'b1, 2'd2, 32'h0);
        chk("basic_status", rd_pre & RD_MASK, 32'h0);

        // overrun: second DATA write four cycles into the transfer is dropped
        step(1'b0, 1'b1, 1'b0, 2'd0, 32'h38);
        idle(); idle(); idle();
        step(1'b0, 1'b1, 1'b0, 2'd0, 32'h0C);
        step(1'b0, 1'b1, 1'b1, 2'd2, 32'h0);
        chk("ovr_status_busy", rd_pre & RD_MASK, 32'h3);
        chk("ovr_out_kept", 32'(out_port), 32'h38);
        guard = 0;
        while (busy && guard < 40) begin idle(); guard++; end
        chk("ovr_busy_timeout", 32'(busy), 32'd0);
        step(1'b0, 1'b1, 1'b1, 2'd2, 32'h0);
        chk("ovr_sticky", rd_pre & RD_MASK, 32'h2);
        step(1'b0, 1'b1, 1'b0, 2'd2, 32'h2);
        step(1'b0, 1'b1, 1'b1, 2'd2, 32'h0);
        chk("ovr_cleared", rd_pre & RD_MASK, 32'h0);

        // reset during the fifth PULSE cycle
        step(1'b0, 1'b1, 1'b0, 2'd0, 32'h5A);
        e_cnt = 0; guard = 0;
        while (e_cnt < 5 && guard < 30) begin
            idle(); guard++;
            if (lcd_e) e_cnt++;
        end
        chk("rst_pulse_reached", 32'(e_cnt), 32'd5);
        step(1'b1, 1'b0, 1'b1, 2'd0, 32'h0);
        chk("rst_lcd_e", 32'(lcd_e), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_out",   32'(out_port), 32'd0);
        idle();

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            step(($urandom % 300) == 0, 1'($urandom % 2), ($urandom % 4) != 0,
                 2'($urandom % 4), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
